hash_result_checker: RTL and testbench
======================================

# hash_result_checker

Parametrised, pipelined successor to the combinational hash validator. It accepts finished `HashState` results plus nonces from `NUM_CORES` SHA cores and checks each against a bit-granular difficulty of leading zero bits. Winning nonces pass through a round-robin arbiter into a small FIFO that the host interface drains with a ready/valid handshake. It also keeps running hash and hit counters.

## Interface
Parameters:
- `NUM_CORES`, 4: number of SHA core input channels (1..16).
- `FIFO_DEPTH`, 4: winner FIFO entries; must be a power of two, ≥2.
- `DIFF_W`, 9: difficulty width; difficulty range is 0..256 bits.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `difficulty`  in  `DIFF_W`  required leading zero bits; sampled on each accepted input.
- `in_valid`  in  `NUM_CORES`  per-core result valid.
- `in_ready`  out  `NUM_CORES`  per-core result ready.
- `in_state`  in  `NUM_CORES` × `HashState`  per-core final hash state.
- `in_nonce`  in  `NUM_CORES` × 32  per-core nonce.
- `out_valid`  out  1  winner available.
- `out_ready`  in  1  host consumes winner.
- `out_nonce`  out  32  winning nonce.
- `out_core`  out  `$clog2(NUM_CORES)` (min 1)  index of the core that produced the winner.
- `hash_count`  out  32  accepted results, wraps modulo 2^32.
- `hit_count`  out  32  results that passed, wraps modulo 2^32.

## Operation
Bit order:
- Hash words are ordered `a`..`h`, with `a` most significant.
- Leading-zero bits are counted from `a[31]` downward.
- A result passes iff its top `difficulty` bits are all zero.
- `difficulty` = 0 always passes. `difficulty` ≥ 256 requires all 256 bits zero.
- `difficulty` = 32·k reproduces word-granular checking of k words.

Stage 1, accept and check, per core i:
- Transfer occurs when `in_valid[i] & in_ready[i]`.
- `in_ready[i]` = `!pending[i]`.
- On transfer: compute pass using the current `difficulty`.
- If pass: set `pending[i]` and latch the nonce into `hold_nonce[i]`.
- If fail: discard.

Stage 2, arbitrate:
- Round-robin grant among set `pending` bits, at most one grant per cycle.
- A grant happens only if the FIFO is not full.
- The granted core's `pending` clears, and its nonce plus core index are pushed into the FIFO.
- The round-robin pointer moves to granted index + 1, modulo `NUM_CORES`.
- If the FIFO is full: no grant, `pending` bits hold, and their `in_ready` stays low (backpressure; nothing is dropped).

FIFO:
- Show-ahead (first-word fall-through). `out_valid` = not empty; `out_nonce` and `out_core` show the head entry.
- Pop on `out_valid & out_ready`.
- Push and pop in the same cycle when full is legal: the pop frees the slot.
- Read and write pointers wrap at `FIFO_DEPTH`.

Counters:
- `hash_count` += popcount of accepted transfers per cycle.
- `hit_count` += popcount of passing transfers per cycle.

## Timing
- Reset values:
  - `pending` = 0; round-robin pointer = 0; FIFO empty.
  - `out_valid` = 0, `out_nonce` = 0, `out_core` = 0.
  - `in_ready` = all ones.
  - `hash_count` = 0, `hit_count` = 0.
- Latency from a passing transfer in cycle N:
  - `pending` is set at N+1.
  - Granted in N+1 if uncontested, so the FIFO write completes at the end of N+1.
  - With the FIFO empty, `out_valid` rises at N+2.
- Throughput: one winner per cycle into the FIFO; failing results are accepted every cycle on every channel.
- `in_ready[i]` is low from N+1 until the cycle after the grant.
- Counters update at the clock edge ending the transfer cycle.
- Reset mid-operation clears all pending results, FIFO contents and counters immediately (asynchronous); no output is produced from pre-reset inputs.

## Structure
- Shared package `sha_pkg` holds the existing `HashState` typedef.
- `sha_pkg` additionally gets:
  - `HASH_BITS` = 256.
  - A `Winner` struct typedef with `nonce` and `core` fields.
- Sub-module `winner_fifo`:
  - Parametrised by `FIFO_DEPTH`, storing `Winner`.
  - Provides push/full and pop/empty.
  - Uses the same `clk`/`rst`.
- The leading-zero check is a combinational function in `sha_pkg`.

## Test plan
- `difficulty` = 0, core 0 sends nonce 0x1 once, `out_ready` = 1. Required: `out_valid` at N+2 with `out_nonce` = 0x1, `out_core` = 0; `hash_count` = 1, `hit_count` = 1.
- `difficulty` = 33, `a` = 0, `b` = 0x8000_0000. Required: rejected and counted in `hash_count` only. Then `b` = 0x4000_0000 passes.
- All 4 cores pass in the same cycle, `out_ready` = 1. Required: winners emerge in core order 0,1,2,3 on consecutive cycles; next simultaneous burst after core 3 is granted starts at core 0.
- `FIFO_DEPTH` = 4, `out_ready` = 0, 6 passing results from core 2. Required:
  - 4 are stored and the 5th is held pending.
  - `in_ready[2]` = 0.
  - Raising `out_ready` delivers all 6 in order, with no loss.
- `difficulty` = 256 with an all-zero state passes; `difficulty` = 256 with `h` = 1 fails.
- Assert `rst` with 2 FIFO entries and 1 pending result. Required: `out_valid` drops immediately, counters read 0, `in_ready` goes all ones, and no stale winner appears after reset release.

Source files
------------

// File: rtl/sha_pkg.sv
// sha_pkg: types shared by the SHA cores and the result checker.
//   HashState        - final 256-bit hash state, word a most significant.
//   Winner           - FIFO entry: winning nonce plus producing core index.
//   leading_zeros_ok - true when the top `diff` bits of a state are zero.
package sha_pkg;

    localparam int unsigned HASH_BITS  = 256;
    localparam int unsigned MAX_CORE_W = 4;   // enough for 16 cores

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

    typedef struct packed {
        logic [31:0]           nonce;
        logic [MAX_CORE_W-1:0] core;
    } Winner;

    // Bit i of the check (counting from a[31] downward) is only enforced when
    // i < diff, so diff = 0 always passes and diff >= 256 checks every bit.
    function automatic logic leading_zeros_ok(input HashState s, input int unsigned diff);
        logic [HASH_BITS-1:0] bits;
        logic                 ok;
        bits = s;
        ok   = 1'b1;
        for (int unsigned i = 0; i < HASH_BITS; i++) begin
            if (i < diff && bits[HASH_BITS-1-i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/winner_fifo.sv
// winner_fifo: show-ahead FIFO of Winner entries.
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data (taken when not full, or full with a pop)
//   push_data  - entry to write
//   full       - no free slot
//   pop        - consume head (ignored when empty)
//   head       - current head entry (all zeros when empty after reset)
//   empty      - no entries
module winner_fifo
    import sha_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  Winner push_data,
    output logic  full,
    input  logic  pop,
    output Winner head,
    output logic  empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    Winner          mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic           do_pop;
    logic           do_push;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hash_result_checker.sv
// hash_result_checker: checks finished hash states from NUM_CORES SHA cores
// against a bit-granular leading-zero difficulty, arbitrates winners
// round-robin into a FIFO and keeps running hash/hit counters.
//   clk, rst    - clock, asynchronous active-high reset
//   difficulty  - required leading zero bits (0..256)
//   in_valid    - per-core result valid
//   in_ready    - per-core result ready (low while that core has a winner pending)
//   in_state    - per-core final hash state
//   in_nonce    - per-core nonce
//   out_valid   - winner available at FIFO head
//   out_ready   - host consumes the head winner
//   out_nonce   - head winner nonce
//   out_core    - head winner core index
//   hash_count  - accepted results (wraps)
//   hit_count   - passing results (wraps)
module hash_result_checker
    import sha_pkg::*;
#(
    parameter  int unsigned NUM_CORES  = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned DIFF_W     = 9,
    localparam int unsigned CORE_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DIFF_W-1:0]              difficulty,
    input  logic [NUM_CORES-1:0]           in_valid,
    output logic [NUM_CORES-1:0]           in_ready,
    input  HashState [NUM_CORES-1:0]       in_state,
    input  logic [NUM_CORES-1:0][31:0]     in_nonce,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_nonce,
    output logic [CORE_W-1:0]              out_core,
    output logic [31:0]                    hash_count,
    output logic [31:0]                    hit_count
);

    logic [NUM_CORES-1:0]        pending;
    logic [NUM_CORES-1:0][31:0]  hold_nonce;
    logic [CORE_W-1:0]           rr_ptr;

    logic [NUM_CORES-1:0]        xfer;
    logic [NUM_CORES-1:0]        pass;
    logic [NUM_CORES-1:0]        hit_vec;
    logic [NUM_CORES-1:0]        gnt_oh;
    logic                        gnt_valid;
    logic [CORE_W-1:0]           gnt_idx;
    logic                        can_grant;

    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    Winner                       push_data;
    Winner                       head;
    int unsigned                 diff_u;
    logic                        unused_core_bits;

    assign in_ready  = ~pending;
    assign diff_u    = 32'(difficulty);
    assign xfer      = in_valid & in_ready;
    assign hit_vec   = xfer & pass;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_nonce = head.nonce;
    assign out_core  = CORE_W'(head.core);
    assign unused_core_bits = ^head.core;

    // A full FIFO can still take a winner when the host pops in the same cycle.
    assign can_grant = !fifo_full || pop;

    always_comb begin
        pass = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            pass[i] = leading_zeros_ok(in_state[i], diff_u);
        end
    end

    // Round-robin search starting at rr_ptr; first pending core found wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_CORES;
            if (can_grant && !gnt_valid && pending[idx]) begin
                gnt_valid   = 1'b1;
                gnt_idx     = CORE_W'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        push_data       = '0;
        push_data.nonce = hold_nonce[gnt_idx];
        push_data.core  = MAX_CORE_W'(gnt_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            hold_nonce <= '0;
            rr_ptr     <= '0;
            hash_count <= '0;
            hit_count  <= '0;
        end else begin
            // A core cannot transfer while pending, so set and clear never collide.
            pending <= (pending & ~gnt_oh) | hit_vec;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (hit_vec[i]) begin
                    hold_nonce[i] <= in_nonce[i];
                end
            end
            if (gnt_valid) begin
                rr_ptr <= (gnt_idx == CORE_W'(NUM_CORES - 1)) ? '0 : gnt_idx + CORE_W'(1);
            end
            hash_count <= hash_count + 32'($countones(xfer));
            hit_count  <= hit_count + 32'($countones(hit_vec));
        end
    end

    winner_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (gnt_valid),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_hash_result_checker.sv
module tb_hash_result_checker;
    import sha_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [8:0]         difficulty;
    logic [3:0]         in_valid;
    logic [3:0]         in_ready;
    HashState [3:0]     in_state;
    logic [3:0][31:0]   in_nonce;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_nonce;
    logic [1:0]         out_core;
    logic [31:0]        hash_count;
    logic [31:0]        hit_count;

    int checks   = 0;
    int failures = 0;

    HashState st;
    HashState ones_st;
    int       got;
    logic     x;

    hash_result_checker #(
        .NUM_CORES  (4),
        .FIFO_DEPTH (4),
        .DIFF_W     (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .difficulty (difficulty),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_nonce   (in_nonce),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nonce  (out_nonce),
        .out_core   (out_core),
        .hash_count (hash_count),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int c, input string tag);
        int n;
        n = 0;
        while (!in_ready[c] && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {63'b0, in_ready[c]}, 64'd1);
    endtask

    initial begin
        ones_st    = '1;
        rst        = 1'b1;
        in_valid   = '0;
        out_ready  = 1'b0;
        difficulty = '0;
        for (int i = 0; i < 4; i++) begin
            in_state[i] = ones_st;
            in_nonce[i] = '0;
        end
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_nonce", out_nonce, 0);
        chk("rst_out_core", out_core, 0);
        chk("rst_in_ready", in_ready, 4'hF);
        chk("rst_hash_count", hash_count, 0);
        chk("rst_hit_count", hit_count, 0);

        // difficulty 0, single winner from core 0
        difficulty  = 9'd0;
        out_ready   = 1'b1;
        in_nonce[0] = 32'h1;
        in_valid    = 4'b0001;
        tick();
        in_valid = '0;
        chk("t1_out_valid_n1", out_valid, 0);
        chk("t1_in_ready_n1", in_ready, 4'b1110);
        chk("t1_hash_count", hash_count, 1);
        chk("t1_hit_count", hit_count, 1);
        tick();
        chk("t1_out_valid_n2", out_valid, 1);
        chk("t1_out_nonce", out_nonce, 32'h1);
        chk("t1_out_core", out_core, 0);
        chk("t1_in_ready_n2", in_ready, 4'hF);
        tick();
        chk("t1_drained", out_valid, 0);

        // difficulty 33: bit 32 set fails, bit 33 set passes
        difficulty  = 9'd33;
        st          = ones_st;
        st.a        = 32'h0;
        st.b        = 32'h8000_0000;
        in_state[1] = st;
        in_nonce[1] = 32'h21;
        in_valid    = 4'b0010;
        tick();
        in_valid = '0;
        chk("t2_fail_hash", hash_count, 2);
        chk("t2_fail_hit", hit_count, 1);
        chk("t2_fail_in_ready", in_ready, 4'hF);
        tick();
        chk("t2_fail_no_out", out_valid, 0);
        st.b        = 32'h4000_0000;
        in_state[1] = st;
        in_nonce[1] = 32'h22;
        in_valid    = 4'b0010;
        tick();
        in_valid = '0;
        chk("t2_pass_hash", hash_count, 3);
        chk("t2_pass_hit", hit_count, 2);
        chk("t2_pass_in_ready", in_ready, 4'b1101);
        tick();
        chk("t2_pass_out_valid", out_valid, 1);
        chk("t2_pass_out_nonce", out_nonce, 32'h22);
        chk("t2_pass_out_core", out_core, 1);
        tick();
        chk("t2_drained", out_valid, 0);

        // fresh reset so the round-robin pointer starts at 0
        rst = 1'b1;
        #1;
        rst = 1'b0;
        in_state[1] = ones_st;

        // all four cores pass together
        difficulty = 9'd0;
        for (int i = 0; i < 4; i++) in_nonce[i] = 32'h30 + i;
        in_valid = 4'hF;
        tick();
        in_valid = '0;
        chk("t3_in_ready_all_pending", in_ready, 4'h0);
        chk("t3_hash_count", hash_count, 4);
        chk("t3_hit_count", hit_count, 4);
        chk("t3_out_valid_n1", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) chk("t3_in_ready_after_first", in_ready, 4'b0001);
            chk("t3_b1_out_valid", out_valid, 1);
            chk("t3_b1_out_nonce", out_nonce, 32'h30 + k);
            chk("t3_b1_out_core", out_core, k);
        end
        chk("t3_in_ready_free", in_ready, 4'hF);
        for (int i = 0; i < 4; i++) in_nonce[i] = 32'h40 + i;
        in_valid = 4'hF;
        tick();
        in_valid = '0;
        chk("t3_b2_gap", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_b2_out_valid", out_valid, 1);
            chk("t3_b2_out_nonce", out_nonce, 32'h40 + k);
            chk("t3_b2_out_core", out_core, k);
        end
        tick();
        chk("t3_drained", out_valid, 0);
        chk("t3_hash_total", hash_count, 8);
        chk("t3_hit_total", hit_count, 8);

        // backpressure: 5 winners from core 2 with out_ready low
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_ready(2, "t4_ready_timeout");
            in_nonce[2]  = 32'h50 + j;
            in_valid[2]  = 1'b1;
            tick();
            in_valid[2] = 1'b0;
        end
        chk("t4_in_ready2_low", in_ready[2], 0);
        tick();
        tick();
        chk("t4_in_ready2_held", in_ready[2], 0);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_head_nonce", out_nonce, 32'h50);
        chk("t4_hash_count", hash_count, 13);
        chk("t4_hit_count", hit_count, 13);
        in_nonce[2] = 32'h55;
        in_valid[2] = 1'b1;
        tick();
        chk("t4_sixth_blocked", hash_count, 13);
        out_ready = 1'b1;
        got       = 0;
        for (int n = 0; n < 40 && got < 6; n++) begin
            x = in_valid[2] & in_ready[2];
            if (out_valid) begin
                chk("t4_drain_nonce", out_nonce, 32'h50 + got);
                chk("t4_drain_core", out_core, 2);
                got++;
            end
            tick();
            if (x) in_valid[2] = 1'b0;
        end
        chk("t4_drain_count", got, 6);
        chk("t4_drain_empty", out_valid, 0);
        chk("t4_hash_total", hash_count, 14);
        chk("t4_hit_total", hit_count, 14);

        // difficulty 256: all-zero passes, h = 1 fails
        difficulty  = 9'd256;
        in_state[3] = '0;
        in_nonce[3] = 32'h60;
        in_valid    = 4'b1000;
        tick();
        in_valid = '0;
        chk("t5_zero_in_ready", in_ready, 4'b0111);
        chk("t5_zero_hash", hash_count, 15);
        chk("t5_zero_hit", hit_count, 15);
        tick();
        chk("t5_zero_out_valid", out_valid, 1);
        chk("t5_zero_out_nonce", out_nonce, 32'h60);
        chk("t5_zero_out_core", out_core, 3);
        tick();
        chk("t5_zero_drained", out_valid, 0);
        st          = '0;
        st.h        = 32'h1;
        in_state[3] = st;
        in_nonce[3] = 32'h61;
        in_valid    = 4'b1000;
        tick();
        in_valid = '0;
        chk("t5_h1_hash", hash_count, 16);
        chk("t5_h1_hit", hit_count, 15);
        chk("t5_h1_in_ready", in_ready, 4'hF);
        tick();
        chk("t5_h1_no_out", out_valid, 0);

        // reset with two FIFO entries and one pending result
        difficulty  = 9'd0;
        out_ready   = 1'b0;
        in_state[3] = ones_st;
        for (int i = 0; i < 3; i++) in_nonce[i] = 32'h70 + i;
        in_valid = 4'b0111;
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("t6_pre_in_ready", in_ready, 4'b1011);
        chk("t6_pre_out_valid", out_valid, 1);
        chk("t6_pre_out_nonce", out_nonce, 32'h70);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_nonce", out_nonce, 0);
        chk("t6_rst_hash", hash_count, 0);
        chk("t6_rst_hit", hit_count, 0);
        chk("t6_rst_in_ready", in_ready, 4'hF);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t6_no_stale_winner", out_valid, 0);
        end
        chk("t6_post_hash", hash_count, 0);
        chk("t6_post_in_ready", in_ready, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
